// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   - funct3 width/sign codes for loads and stores
//   - FSM state encoding
//   - writeback error codes
//   - funct3 legality helper
package lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Writeback error codes
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FUNCT3   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Stores only know byte/half/word; loads add the unsigned byte/half forms.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) begin
      ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    end else begin
      ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   is_store_i    1 = store, 0 = load
//   funct3_i      RV32I width/sign code
//   offset_i      byte offset within the word (addr[1:0])
//   store_data_i  rs2 value
//   load_word_i   word returned by the bus
//   wmask_o       byte strobes for a store (0 for loads)
//   wdata_o       lane-replicated store data (0 for loads)
//   load_data_o   extracted, sign/zero-extended load data
//   misaligned_o  halfword on an odd byte or word not on a word boundary
//   illegal_o     funct3 not valid for this access direction
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wmask_o      = 4'b0000;
    wdata_o      = '0;
    load_data_o  = '0;
    misaligned_o = 1'b0;
    illegal_o    = !funct3_legal(is_store_i, funct3_i);

    byte_sel = load_word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];

    // Width lives in funct3[1:0] for both loads and stores.
    case (funct3_i[1:0])
      2'b01:   misaligned_o = offset_i[0];
      2'b10:   misaligned_o = (offset_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase

    if (is_store_i) begin
      case (funct3_i)
        SB: begin
          wmask_o = 4'b0001 << offset_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        SH: begin
          wmask_o = 4'b0011 << {offset_i[1], 1'b0};
          wdata_o = {2{store_data_i[15:0]}};
        end
        SW: begin
          wmask_o = 4'b1111;
          wdata_o = store_data_i;
        end
        default: begin
          wmask_o = 4'b0000;
          wdata_o = '0;
        end
      endcase
    end else begin
      case (funct3_i)
        LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
        LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
        LW:      load_data_o = load_word_i;
        LBU:     load_data_o = {24'h000000, byte_sel};
        LHU:     load_data_o = {16'h0000, half_sel};
        default: load_data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store stage.
//   clk, rst                  clock, synchronous active-high reset
//   req_*                     request from execute (valid/ready handshake)
//   mem_req_*, mem_wen,
//   mem_addr/wdata/wmask      word-aligned bus request with byte strobes
//   mem_rsp_valid/rdata       bus response (sampled only in WAIT)
//   wb_*                      writeback result (valid/ready), error code
// Flow: IDLE -> REQ -> WAIT -> RESP -> IDLE, or IDLE -> RESP directly when
// the request is malformed (no bus traffic in that case).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      wb_err
);

  lsu_state_e           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 store_q, store_d;
  logic [4:0]           rd_q, rd_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_wmask_q, mem_wmask_d;
  logic                 mem_wen_q, mem_wen_d;
  logic                 wb_we_q, wb_we_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic [1:0]           wb_err_q, wb_err_d;

  // A single aligner serves both phases: in IDLE it looks at the incoming
  // request (checks + store lanes, captured at accept); afterwards it looks
  // at the captured offset/funct3 so the response word can be extracted.
  logic        live_sel;
  logic        al_is_store;
  logic [2:0]  al_funct3;
  logic [1:0]  al_offset;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;
  logic        al_illegal;

  assign live_sel    = (state_q == IDLE);
  assign al_is_store = live_sel ? req_is_store  : store_q;
  assign al_funct3   = live_sel ? req_funct3    : funct3_q;
  assign al_offset   = live_sel ? req_addr[1:0] : off_q;

  lsu_lane_align u_lane_align (
    .is_store_i   (al_is_store),
    .funct3_i     (al_funct3),
    .offset_i     (al_offset),
    .store_data_i (req_wdata),
    .load_word_i  (mem_rsp_rdata),
    .wmask_o      (al_wmask),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load_data),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  // Handshake outputs are forced low while reset is asserted so that a
  // request presented together with rst is never seen as accepted.
  assign req_ready     = !rst && (state_q == IDLE);
  assign mem_req_valid = !rst && (state_q == REQ);
  assign wb_valid      = !rst && (state_q == RESP);

  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    mem_wen_d   = mem_wen_q;
    wb_we_d     = wb_we_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          off_d       = req_addr[1:0];
          funct3_d    = req_funct3;
          store_d     = req_is_store;
          rd_d        = req_rd;
          mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
          mem_wdata_d = al_wdata;
          mem_wmask_d = al_wmask;
          mem_wen_d   = req_is_store;
          wb_we_d     = 1'b0;
          wb_data_d   = '0;
          wb_err_d    = ERR_NONE;
          // funct3 legality takes priority over alignment.
          if (al_illegal) begin
            wb_err_d = ERR_FUNCT3;
            state_d  = RESP;
          end else if (al_misaligned) begin
            wb_err_d = ERR_MISALIGN;
            state_d  = RESP;
          end else begin
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          wb_err_d  = ERR_NONE;
          wb_we_d   = !store_q;
          wb_data_d = store_q ? '0 : al_load_data;
          state_d   = RESP;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          wb_err_d  = ERR_TIMEOUT;
          wb_we_d   = 1'b0;
          wb_data_d = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_wen_q   <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_data_q   <= '0;
      wb_err_q    <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wen_q   <= mem_wen_d;
      wb_we_q     <= wb_we_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of single transactions plus
// hand-written sequences for bus back-pressure, timeout and mid-flight reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid, wb_ready, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_err;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus;     // a bus request is expected
    logic [3:0]  wmask;
    logic [31:0] mwdata;
    logic        we;
    logic [31:0] data;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic [1:0]  err;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int id, input vec_t v, input int ready_lat,
                         input int rsp_lat, input int wb_lat, input int exp_lat);
    exp_t        e, got;
    int          cyc;
    logic [31:0] d0;
    e.we = v.we; e.data = v.data; e.err = v.err; e.rd = 5'(id + 1); e.lat = exp_lat;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = e.rd;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; cyc = 1;
    if (v.bus) begin
      for (int i = 0; i <= ready_lat; i++) begin
        if (i > 0) begin @(negedge clk); cyc++; end
        chk("mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, v.wmask});
        chk("mem_wen", {31'b0, mem_wen}, {31'b0, v.st});
        if (v.st) chk("mem_wdata", mem_wdata, v.mwdata);
      end
      mem_req_ready = 1'b1;
      @(negedge clk); cyc++;
      mem_req_ready = 1'b0;
      if (rsp_lat >= 0) begin
        repeat (rsp_lat) begin
          @(negedge clk); cyc++;
          chk("wb_valid_early", {31'b0, wb_valid}, 32'd0);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata;
        @(negedge clk); cyc++;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
      end
    end else begin
      chk("no_bus_req", {31'b0, mem_req_valid}, 32'd0);
    end
    while (!wb_valid && cyc < 60) begin
      @(negedge clk); cyc++;
    end
    if (!wb_valid) begin
      chk("wb_valid_wait", 32'd0, 32'd1);
      sb_q.delete();
      return;
    end
    got = sb_q.pop_front();
    if (got.lat >= 0) chk("latency", cyc, got.lat);
    chk("wb_we", {31'b0, wb_we}, {31'b0, got.we});
    chk("wb_data", wb_data, got.data);
    chk("wb_err", {30'b0, wb_err}, {30'b0, got.err});
    chk("wb_rd", {27'b0, wb_rd}, {27'b0, got.rd});
    d0 = wb_data;
    repeat (wb_lat) begin
      @(negedge clk);
      chk("wb_hold_valid", {31'b0, wb_valid}, 32'd1);
      chk("wb_hold_data", wb_data, d0);
      chk("wb_hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("idle_after_wb", {31'b0, req_ready}, 32'd1);
    chk("wb_valid_drop", {31'b0, wb_valid}, 32'd0);
    $display("txn %0d st=%0d f3=%0d addr=%h wb_data=%h err=%0d lat=%0d",
             id, v.st, v.f3, v.addr, d0, got.err, cyc);
  endtask

  initial begin
    //           st  f3     addr          wdata         rdata         bus wmask    mwdata        we  data          err
    vecs[0]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0,         1'b1, 32'hDEAD_BEEF, 2'd0};
    vecs[1]  = '{1'b0, 3'b000, 32'h1000_0003, 32'h0,         32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'hFFFF_FF80, 2'd0};
    vecs[2]  = '{1'b0, 3'b100, 32'h1000_0003, 32'h0,         32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_0080, 2'd0};
    vecs[3]  = '{1'b0, 3'b101, 32'h1000_0002, 32'h0,         32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_80FF, 2'd0};
    vecs[4]  = '{1'b0, 3'b001, 32'h1000_0002, 32'h0,         32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'hFFFF_80FF, 2'd0};
    vecs[5]  = '{1'b0, 3'b000, 32'h1000_0000, 32'h0,         32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_0034, 2'd0};
    vecs[6]  = '{1'b0, 3'b001, 32'h1000_0000, 32'h0,         32'h80FF_9234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'hFFFF_9234, 2'd0};
    vecs[7]  = '{1'b0, 3'b100, 32'h1000_0001, 32'h0,         32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_0012, 2'd0};
    vecs[8]  = '{1'b1, 3'b000, 32'h2000_0002, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b1, 4'b0100, 32'hA5A5_A5A5, 1'b0, 32'h0,         2'd0};
    vecs[9]  = '{1'b1, 3'b001, 32'h2000_0002, 32'h1234_BEEF, 32'hFFFF_FFFF, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0,         2'd0};
    vecs[10] = '{1'b1, 3'b010, 32'h2000_0008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,         2'd0};
    vecs[11] = '{1'b1, 3'b010, 32'h2000_0002, 32'h1111_1111, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         2'd1};
    vecs[12] = '{1'b0, 3'b011, 32'h2000_0000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         2'd2};
    vecs[13] = '{1'b0, 3'b001, 32'h2000_0001, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         2'd1};
    vecs[14] = '{1'b1, 3'b100, 32'h2000_0000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         2'd2};

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; wb_ready = 1'b0;

    // Reset state, with a request presented alongside rst.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0000;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("post_rst_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("post_rst_wb_data", wb_data, 32'd0);
    chk("post_rst_wb_err", {30'b0, wb_err}, 32'd0);

    // Table: minimal-latency bus timing (3 cycles), errors respond after 1.
    for (int i = 0; i < 15; i++) begin
      run_txn(i, vecs[i], 0, 0, 0, vecs[i].bus ? 3 : 1);
    end

    // Bus back-pressure for 5 cycles, slow response, writeback stalled 3 cycles.
    run_txn(20, vecs[9], 5, 2, 3, 10);
    // No response ever: timeout after 4 WAIT cycles.
    begin
      vec_t t;
      t = vecs[0];
      t.we = 1'b0; t.data = 32'h0; t.err = 2'd3;
      run_txn(21, t, 0, -1, 0, 6);
    end

    // Reset while in WAIT, then a late response must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h3000_0000; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_in_req", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_req_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rstmid_idle", {31'b0, req_ready}, 32'd1);
      chk("rstmid_no_bus", {31'b0, mem_req_valid}, 32'd0);
      @(negedge clk);
    end
    $display("txn rst_mid_wait late response ignored");
    run_txn(22, vecs[0], 0, 0, 0, 3);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
